// File: rtl/fsm_bist_gen2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_bist_gen2_pkg
//  Description : Shared types and default sizing for the vector-replay BIST
//                sequencer (fsm_bist_gen2) and its vector memory.
//  Contents    : bist_state_e - sequencer state encoding
//                c_default_*  - default parameter values
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_bist_gen2_pkg;

  // Default vector memory depth (power of two, at least 4).
  localparam int c_default_depth = 128;
  // Default width of the stimulus (drive) field of a vector word.
  localparam int c_default_drv_w = 4;
  // Default width of the observed/reference state field of a vector word.
  localparam int c_default_st_w  = 4;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

endpackage : fsm_bist_gen2_pkg
`default_nettype wire

// File: rtl/bist_vec_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bist_vec_ram
//  Description : Single-port vector memory with one write port and a
//                registered (one-cycle latency) read. The same address serves
//                writes and reads; a read in the cycle of a write to the same
//                location returns the old contents.
//  Ports       : clk     - clock
//                i_we    - write enable
//                i_addr  - word address
//                i_wdata - write data
//                o_rdata - read data, valid the cycle after i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_vec_ram
  import fsm_bist_gen2_pkg::*;
#(
  parameter  int DEPTH = c_default_depth,
  parameter  int W     = c_default_drv_w + c_default_st_w,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Storage is intentionally not reset: vector contents must survive a
  // reset of the sequencer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule : bist_vec_ram
`default_nettype wire

// File: rtl/fsm_bist_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_bist_gen2
//  Description : Vector-replay BIST sequencer. Replays a block of stored
//                vectors onto an external state machine (drive field) and
//                compares its observed state one cycle later against the
//                stored reference field. Counts mismatches and captures the
//                context of the first one.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start_i, abort_i    - start pulse / abort of a running test
//                stop_on_fail_i      - end test at first mismatch (at start)
//                base_i, len_i       - first vector address, vector count
//                state_i / drive_o   - observed state / stimulus
//                mem_we_i, mem_addr_i, mem_wdata_i, mem_rdata_o
//                                    - host access to the vector memory
//                busy_o, done_o, pass_o, fault_cnt_o
//                                    - status and result
//                first_idx_o, first_drv_o, first_ref_o, first_got_o,
//                first_prev_o        - first-mismatch capture
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_bist_gen2
  import fsm_bist_gen2_pkg::*;
#(
  parameter  int DEPTH = c_default_depth,
  parameter  int DRV_W = c_default_drv_w,
  parameter  int ST_W  = c_default_st_w,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int VW    = DRV_W + ST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stop_on_fail_i,
  input  logic [AW-1:0]    base_i,
  input  logic [CW-1:0]    len_i,
  input  logic [ST_W-1:0]  state_i,
  output logic [DRV_W-1:0] drive_o,
  input  logic             mem_we_i,
  input  logic [AW-1:0]    mem_addr_i,
  input  logic [VW-1:0]    mem_wdata_i,
  output logic [VW-1:0]    mem_rdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CW-1:0]    fault_cnt_o,
  output logic [CW-1:0]    first_idx_o,
  output logic [DRV_W-1:0] first_drv_o,
  output logic [ST_W-1:0]  first_ref_o,
  output logic [ST_W-1:0]  first_got_o,
  output logic [ST_W-1:0]  first_prev_o
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  bist_state_e      r_state;
  bist_state_e      w_state_nxt;

  logic [AW-1:0]    r_base;
  logic [CW-1:0]    r_len;
  logic             r_stop;
  logic [CW-1:0]    r_k;          // index of the vector driven this RUN cycle
  logic [AW-1:0]    r_rd_addr;    // address of the next vector read

  // Vector driven in the previous cycle, compared in this cycle.
  logic             r_cmp_valid;
  logic [CW-1:0]    r_cmp_idx;
  logic [DRV_W-1:0] r_cmp_drv;
  logic [ST_W-1:0]  r_cmp_ref;
  logic [ST_W-1:0]  r_prev_state; // state_i at the previous compare (or PRIME)

  logic             r_pass;
  logic [CW-1:0]    r_fault_cnt;
  logic [CW-1:0]    r_first_idx;
  logic [DRV_W-1:0] r_first_drv;
  logic [ST_W-1:0]  r_first_ref;
  logic [ST_W-1:0]  r_first_got;
  logic [ST_W-1:0]  r_first_prev;

  logic             w_busy;
  logic             w_abort;
  logic             w_start;
  logic             w_cmp;
  logic             w_mismatch;
  logic             w_first;
  logic             w_last;
  logic [CW-1:0]    w_fault_nxt;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_addr;
  logic [VW-1:0]    w_rdata;

  // --------------------------------------------------------------------------
  // Vector memory. While a test runs the sequencer owns the address port and
  // host writes are dropped.
  // --------------------------------------------------------------------------
  assign w_ram_we   = mem_we_i && (r_state == ST_IDLE);
  assign w_ram_addr = w_busy ? r_rd_addr : mem_addr_i;

  bist_vec_ram #(
    .DEPTH (DEPTH),
    .W     (VW)
  ) u_vec_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (mem_wdata_i),
    .o_rdata (w_rdata)
  );

  assign mem_rdata_o = w_rdata;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign w_busy  = (r_state != ST_IDLE);
  assign w_abort = abort_i && w_busy;
  // Abort together with start in IDLE suppresses the start.
  assign w_start = start_i && !abort_i && (r_state == ST_IDLE);

  // A compare is pending in every RUN cycle after the first and in FLUSH.
  // An abort in the same cycle discards the compare result.
  assign w_cmp      = r_cmp_valid && !abort_i &&
                      ((r_state == ST_RUN) || (r_state == ST_FLUSH));
  assign w_mismatch = w_cmp && (state_i != r_cmp_ref);
  // A zero count means nothing has been captured yet; the saturating count
  // never returns to zero within a test.
  assign w_first    = w_mismatch && (r_fault_cnt == '0);
  assign w_last     = (r_k == (r_len - CW'(1)));

  assign w_fault_nxt = (w_mismatch && (r_fault_cnt != {CW{1'b1}}))
                     ? (r_fault_cnt + CW'(1)) : r_fault_cnt;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (len_i == '0) ? ST_DONE : ST_PRIME;
        end
      end
      ST_PRIME: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // In stop mode the vector already on drive_o in the failing compare
        // cycle is the last one presented.
        if (w_mismatch && r_stop) begin
          w_state_nxt = ST_DONE;
        end else if (w_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Test setup, vector sequencing and compare pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_len        <= '0;
      r_stop       <= 1'b0;
      r_k          <= '0;
      r_rd_addr    <= '0;
      r_cmp_valid  <= 1'b0;
      r_cmp_idx    <= '0;
      r_cmp_drv    <= '0;
      r_cmp_ref    <= '0;
      r_prev_state <= '0;
    end else begin
      if (w_start) begin
        r_base    <= base_i;
        r_len     <= len_i;
        r_stop    <= stop_on_fail_i;
        r_k       <= '0;
        r_rd_addr <= base_i;
      end else if ((r_state == ST_PRIME) || (r_state == ST_RUN)) begin
        // Address wraps modulo DEPTH through natural overflow.
        r_rd_addr <= r_rd_addr + AW'(1);
      end

      if (r_state == ST_RUN) begin
        r_k <= r_k + CW'(1);
      end

      r_cmp_valid <= (r_state == ST_RUN);
      if (r_state == ST_RUN) begin
        r_cmp_idx <= r_k;
        r_cmp_drv <= w_rdata[VW-1:ST_W];
        r_cmp_ref <= w_rdata[ST_W-1:0];
      end

      if ((r_state == ST_PRIME) || w_cmp) begin
        r_prev_state <= state_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Results: held from DONE until the next accepted start
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass       <= 1'b0;
      r_fault_cnt  <= '0;
      r_first_idx  <= '0;
      r_first_drv  <= '0;
      r_first_ref  <= '0;
      r_first_got  <= '0;
      r_first_prev <= '0;
    end else if (w_start) begin
      r_pass       <= (len_i == '0);
      r_fault_cnt  <= '0;
      r_first_idx  <= '0;
      r_first_drv  <= '0;
      r_first_ref  <= '0;
      r_first_got  <= '0;
      r_first_prev <= '0;
    end else if (w_abort) begin
      r_pass <= 1'b0;
    end else begin
      r_fault_cnt <= w_fault_nxt;
      if (w_first) begin
        r_first_idx  <= r_cmp_idx;
        r_first_drv  <= r_cmp_drv;
        r_first_ref  <= r_cmp_ref;
        r_first_got  <= state_i;
        r_first_prev <= r_prev_state;
      end
      // Pass is resolved on entry to DONE so it is valid alongside done_o,
      // including the result of the final compare.
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_pass <= (w_fault_nxt == '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign drive_o      = (r_state == ST_RUN) ? w_rdata[VW-1:ST_W] : '0;
  assign busy_o       = w_busy;
  assign done_o       = (r_state == ST_DONE) && !abort_i;
  assign pass_o       = r_pass;
  assign fault_cnt_o  = r_fault_cnt;
  assign first_idx_o  = r_first_idx;
  assign first_drv_o  = r_first_drv;
  assign first_ref_o  = r_first_ref;
  assign first_got_o  = r_first_got;
  assign first_prev_o = r_first_prev;

endmodule : fsm_bist_gen2
`default_nettype wire

// File: tb/tb_fsm_bist_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_bist_gen2
//  Description : Self-checking bench for fsm_bist_gen2. A toy state machine
//                (state += drive, mod 16) is the unit under test; a cycle
//                model of the test sequence is built from the vector table
//                before each run and compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_bist_gen2;

  localparam int DEPTH = 128;
  localparam int DRV_W = 4;
  localparam int ST_W  = 4;
  localparam int AW    = 7;
  localparam int CW    = 8;
  localparam int VW    = 8;
  localparam int S0    = 3;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic             abort_i;
  logic             stop_on_fail_i;
  logic [AW-1:0]    base_i;
  logic [CW-1:0]    len_i;
  logic [ST_W-1:0]  state_i;
  logic [DRV_W-1:0] drive_o;
  logic             mem_we_i;
  logic [AW-1:0]    mem_addr_i;
  logic [VW-1:0]    mem_wdata_i;
  logic [VW-1:0]    mem_rdata_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [CW-1:0]    fault_cnt_o;
  logic [CW-1:0]    first_idx_o;
  logic [DRV_W-1:0] first_drv_o;
  logic [ST_W-1:0]  first_ref_o;
  logic [ST_W-1:0]  first_got_o;
  logic [ST_W-1:0]  first_prev_o;

  fsm_bist_gen2 #(.DEPTH(DEPTH), .DRV_W(DRV_W), .ST_W(ST_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .stop_on_fail_i(stop_on_fail_i), .base_i(base_i), .len_i(len_i),
    .state_i(state_i), .drive_o(drive_o), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .fault_cnt_o(fault_cnt_o), .first_idx_o(first_idx_o),
    .first_drv_o(first_drv_o), .first_ref_o(first_ref_o),
    .first_got_o(first_got_o), .first_prev_o(first_prev_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy unit under test: state advances by the drive value each cycle.
  logic            tdut_load;
  logic [ST_W-1:0] tdut_init;
  logic [ST_W-1:0] tdut_s;
  always @(posedge clk) begin
    if (tdut_load) tdut_s <= tdut_init;
    else           tdut_s <= tdut_s + drive_o;
  end
  assign state_i = tdut_s;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Bench copy of the vector memory and the per-cycle expectations.
  logic [VW-1:0] mem_model [DEPTH];
  int  exp_busy  [64];
  int  exp_done  [64];
  int  exp_drive [64];
  int  drv_seen  [64];
  int  horizon;
  int  done_seen;
  int  t0;
  bit  mon_en = 1'b0;
  int  m_faults, m_idx, m_drv, m_ref, m_got, m_prev, m_pass;
  int  ld_drv [8];

  // Per-cycle compare: cycle c counts from the start cycle (c=0).
  int mc;
  always @(negedge clk) begin
    if (mon_en) begin
      mc = cyc - t0;
      if (mc >= 1 && mc < 64) begin
        chk("busy_o",  int'(busy_o),  exp_busy[mc]);
        chk("done_o",  int'(done_o),  exp_done[mc]);
        chk("drive_o", int'(drive_o), exp_drive[mc]);
        drv_seen[mc] = int'(drive_o);
        if (done_o) done_seen = mc;
      end
    end
  end

  // Expected test trace from the vector table: vector k is presented in
  // cycle 2+k and the toy state after it is checked in cycle 3+k.
  task automatic build_model(input int base, input int len, input bit stop,
                             input int abort_at);
    int s, prev, dc, d, r, a;
    bit mm;
    for (int i = 0; i < 64; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_drive[i] = 0; drv_seen[i] = 0;
    end
    m_faults = 0; m_idx = 0; m_drv = 0; m_ref = 0; m_got = 0; m_prev = 0;
    s = S0; prev = S0;
    dc = (len == 0) ? 1 : len + 3;
    for (int k = 0; k < len; k++) begin
      a = (base + k) % DEPTH;
      d = int'(mem_model[a][VW-1:ST_W]);
      r = int'(mem_model[a][ST_W-1:0]);
      exp_drive[2+k] = d;
      s = (s + d) % 16;
      mm = (s != r);
      if (mm) begin
        if (m_faults == 0) begin
          m_idx = k; m_drv = d; m_ref = r; m_got = s; m_prev = prev;
        end
        m_faults++;
      end
      prev = s;
      if (mm && stop) begin
        dc = 4 + k;
        if (k + 1 < len) exp_drive[3+k] = int'(mem_model[(a+1)%DEPTH][VW-1:ST_W]);
        break;
      end
    end
    for (int c = 1; c <= dc; c++) exp_busy[c] = 1;
    exp_done[dc] = 1;
    m_pass = (m_faults == 0) ? 1 : 0;
    if (abort_at > 0 && abort_at <= dc) begin
      for (int c = abort_at + 1; c < 64; c++) begin
        exp_busy[c] = 0; exp_drive[c] = 0; exp_done[c] = 0;
      end
      exp_done[abort_at] = 0;
      m_pass = 0;
      dc = abort_at;
    end
    horizon = dc + 2;
  endtask

  task automatic write_vec(input int addr, input int d, input int r);
    @(negedge clk);
    mem_we_i = 1'b1; mem_addr_i = AW'(addr); mem_wdata_i = {4'(d), 4'(r)};
    mem_model[addr] = {4'(d), 4'(r)};
    @(negedge clk);
    mem_we_i = 1'b0;
  endtask

  // Store n vectors whose references match the toy state machine from S0.
  task automatic load_matching(input int base, input int n);
    int s;
    s = S0;
    for (int k = 0; k < n; k++) begin
      s = (s + ld_drv[k]) % 16;
      write_vec((base + k) % DEPTH, ld_drv[k], s);
    end
  endtask

  task automatic readback(input int addr);
    @(negedge clk);
    mem_addr_i = AW'(addr);
    @(negedge clk);
    chk("mem_rdata_o", int'(mem_rdata_o), int'(mem_model[addr]));
  endtask

  task automatic run_test(input int base, input int len, input bit stop,
                          input int abort_at);
    bit spurious;
    build_model(base, len, stop, abort_at);
    spurious = (exp_busy[3] == 1);
    @(negedge clk); tdut_load = 1'b1; tdut_init = 4'(S0);
    @(negedge clk); tdut_load = 1'b0;
    start_i = 1'b1; base_i = AW'(base); len_i = CW'(len);
    stop_on_fail_i = stop; t0 = cyc; done_seen = -1;
    @(posedge clk); #1;
    mon_en = 1'b1; start_i = 1'b0;
    for (int c = 1; c <= horizon; c++) begin
      // A start and a host write while busy must both be ignored.
      start_i = spurious && (c == 3);
      mem_we_i = spurious && (c == 3);
      if (c == 3) begin
        base_i = 7'd5; len_i = 8'd2; mem_addr_i = 7'd40; mem_wdata_i = 8'hA5;
      end
      abort_i = (c == abort_at);
      @(posedge clk); #1;
    end
    start_i = 1'b0; mem_we_i = 1'b0; abort_i = 1'b0; mon_en = 1'b0;
    @(negedge clk);
    chk("busy_o idle after test", int'(busy_o), 0);
    chk("pass_o", int'(pass_o), m_pass);
    if (abort_at < 0) begin
      chk("fault_cnt_o",  int'(fault_cnt_o),  m_faults);
      chk("first_idx_o",  int'(first_idx_o),  m_idx);
      chk("first_drv_o",  int'(first_drv_o),  m_drv);
      chk("first_ref_o",  int'(first_ref_o),  m_ref);
      chk("first_got_o",  int'(first_got_o),  m_got);
      chk("first_prev_o", int'(first_prev_o), m_prev);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; stop_on_fail_i = 1'b0;
    base_i = '0; len_i = '0; mem_we_i = 1'b0; mem_addr_i = '0;
    mem_wdata_i = '0; tdut_load = 1'b1; tdut_init = '0;
    repeat (3) @(negedge clk);
    chk("reset busy_o",      int'(busy_o),      0);
    chk("reset done_o",      int'(done_o),      0);
    chk("reset pass_o",      int'(pass_o),      0);
    chk("reset drive_o",     int'(drive_o),     0);
    chk("reset fault_cnt_o", int'(fault_cnt_o), 0);
    chk("reset first_idx_o", int'(first_idx_o), 0);
    chk("reset first_got_o", int'(first_got_o), 0);
    rst_n = 1'b1; tdut_load = 1'b0;

    // Matching vectors: drives 1..8 from S0=3 give refs 4,6,9,13,2,8,15,7.
    ld_drv = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_matching(0, 8);
    write_vec(40, 5, 10);
    readback(3);
    run_test(0, 8, 1'b0, -1);
    chk("pin done cycle", done_seen, 11);
    chk("pin pass", int'(pass_o), 1);
    readback(40);

    // Vector 3 ref corrupted (13 -> 12), run to completion.
    write_vec(3, 4, 12);
    run_test(0, 8, 1'b0, -1);
    chk("pin fault_cnt", int'(fault_cnt_o), 1);
    chk("pin first_idx", int'(first_idx_o), 3);
    chk("pin first_ref", int'(first_ref_o), 12);
    chk("pin first_got", int'(first_got_o), 13);
    chk("pin first_prev", int'(first_prev_o), 9);
    chk("pin drive last vector", drv_seen[9], 8);
    write_vec(3, 4, 13);

    // Vectors 2 and 5 corrupted, stop at first failure.
    write_vec(2, 3, 8);
    write_vec(5, 6, 9);
    run_test(0, 8, 1'b1, -1);
    chk("pin stop done cycle", done_seen, 6);
    chk("pin stop first_idx", int'(first_idx_o), 2);
    chk("pin stop fault_cnt", int'(fault_cnt_o), 1);
    chk("pin stop drive after done", drv_seen[7], 0);
    write_vec(2, 3, 9);
    write_vec(5, 6, 8);

    // Start together with abort in IDLE: no test begins.
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1; len_i = 8'd8; base_i = '0;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("start+abort busy_o", int'(busy_o), 0);
    @(negedge clk);
    chk("start+abort busy_o later", int'(busy_o), 0);

    // Abort while vector 4 is driven (cycle 6).
    run_test(0, 8, 1'b0, 6);
    chk("pin abort no done", done_seen, -1);
    chk("pin abort busy next", exp_busy[7], int'(busy_o));

    // Zero-length test completes immediately with pass.
    run_test(0, 0, 1'b0, -1);
    chk("pin len0 done cycle", done_seen, 1);
    chk("pin len0 pass", int'(pass_o), 1);

    // Wrapping window 126,127,0,1.
    ld_drv = '{9, 10, 11, 12, 0, 0, 0, 0};
    load_matching(126, 4);
    run_test(126, 4, 1'b0, -1);
    chk("pin wrap drive 126", drv_seen[2], 9);
    chk("pin wrap drive 127", drv_seen[3], 10);
    chk("pin wrap drive 0",   drv_seen[4], 11);
    chk("pin wrap drive 1",   drv_seen[5], 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fsm_bist_gen2
`default_nettype wire

// File: doc/fsm_bist_gen2.md
FSM_BIST_GEN2 -- requirements
Module: fsm_bist_gen2

Interface
REQ-001 SHALL have parameter DEPTH, default 128, vector memory depth (power of two, >=4).
REQ-002 SHALL have parameter DRV_W, default 4, drive field width.
REQ-003 SHALL have parameter ST_W, default 4, observed/reference state width; vector word VW = DRV_W+ST_W, drive in upper bits.
REQ-004 SHALL define AW = $clog2(DEPTH) and CW = AW+1.
REQ-005 Ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Ports: start_i  in  1  start test pulse; abort_i  in  1  abort test; stop_on_fail_i  in  1  mode, sampled at start.
REQ-007 Ports: base_i  in  AW  first vector address; len_i  in  CW  vector count; both sampled at start.
REQ-008 Ports: state_i  in  ST_W  DUT state; drive_o  out  DRV_W  DUT stimulus.
REQ-009 Ports: mem_we_i  in  1; mem_addr_i  in  AW; mem_wdata_i  in  VW; mem_rdata_o  out  VW  host memory access.
REQ-010 Ports: busy_o, done_o, pass_o  out  1 each; fault_cnt_o  out  CW; first_idx_o  out  CW; first_drv_o  out  DRV_W; first_ref_o, first_got_o, first_prev_o  out  ST_W each.

Function
REQ-011 FSM states SHALL be IDLE, PRIME, RUN, FLUSH, DONE.
REQ-012 IDLE + start_i: latch base, len, mode; clear fault_cnt, first_* and pass; go PRIME; if len_i==0 go DONE with pass=1.
REQ-013 PRIME: issue read of base; next cycle go RUN.
REQ-014 RUN: drive_o SHALL equal drive field of vector k in cycle k of RUN; address = (base+k) mod DEPTH, wrap silent.
REQ-015 Vector k's ref SHALL be compared with state_i one cycle after drive_o carries vector k.
REQ-016 After last vector driven, FLUSH SHALL last one cycle for the final compare, then DONE.
REQ-017 Mismatch: fault_cnt increments, saturating at 2^CW-1.
REQ-018 First mismatch only: capture k into first_idx, drive/ref of vector k, got=state_i, prev=state_i of the previous compare cycle (or state_i at PRIME for k=0).
REQ-019 stop_on_fail=1: on first mismatch go DONE immediately; remaining vectors not driven.
REQ-020 DONE: done_o high exactly one cycle; pass_o = (fault_cnt==0); next state IDLE.
REQ-021 pass_o, fault_cnt_o, first_* SHALL hold until next accepted start.
REQ-022 busy_o SHALL be high in PRIME, RUN, FLUSH, DONE.
REQ-023 abort_i in any busy state: go IDLE next cycle, no done_o, pass_o=0; abort has priority over mismatch and completion.
REQ-024 start_i while busy SHALL be ignored; start_i and abort_i together in IDLE: abort wins, no start.
REQ-025 mem_we_i while busy SHALL be ignored; while idle writes mem_wdata_i at mem_addr_i.
REQ-026 mem_rdata_o SHALL return word at mem_addr_i one cycle later when idle; undefined when busy.
REQ-027 drive_o SHALL be 0 outside RUN.

Reset
REQ-028 Reset SHALL force IDLE; drive_o, busy_o, done_o, pass_o, fault_cnt_o, first_* all 0.
REQ-029 Reset mid-run SHALL abandon the test with no done_o; memory contents not cleared.

Structure
REQ-030 Shared package SHALL hold state enum type and default parameter constants.
REQ-031 Vector memory SHALL be a sub-module bist_vec_ram (1 write port, synchronous 1-cycle read).

Verification
REQ-032 Load 8 vectors matching DUT model, base=0, len=8 -> done_o at cycle 11 after start, pass_o=1, fault_cnt=0.
REQ-033 Same, vector 3 ref corrupted, stop_on_fail=0 -> 8 vectors driven, fault_cnt=1, first_idx=3, pass_o=0.
REQ-034 Vectors 2 and 5 corrupted, stop_on_fail=1 -> done after compare of vector 2, drive_o 0 thereafter, fault_cnt=1, first_idx=2.
REQ-035 DEPTH=128, base=126, len=4 -> addresses 126,127,0,1 driven in order.
REQ-036 abort_i during RUN at vector 4 -> busy_o low next cycle, no done_o, pass_o=0; len_i=0 start -> done_o next cycle, pass_o=1.
